// File: rtl/pkt_parser_stream.sv
// Ethernet/IP/TCP header parser with a registered valid/ready payload stage and
// double-buffered header outputs. Define PKT_PARSER_STATS_EN for saturating counters.
//
// state   | meaning
// S_IDLE  | waiting for Ethernet word 0
// S_ETH   | capturing remaining Ethernet words
// S_IP    | capturing IP header words
// S_TCP   | capturing TCP header words, publishes on the final one
// S_PAY   | forwarding payload words to the output register
// S_DROP  | discarding words past the payload limit until last_in
module pkt_parser_stream #(
  parameter int WIDTH             = 32,
  parameter int ETH_WORDS         = 4,
  parameter int IP_WORDS          = 5,
  parameter int TCP_WORDS         = 5,
  parameter int MAX_PAYLOAD_WORDS = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic                       last_out,
  input  logic                       ready_out,
  output logic [ETH_WORDS*WIDTH-1:0] eth_hdr,
  output logic [IP_WORDS*WIDTH-1:0]  ip_hdr,
  output logic [TCP_WORDS*WIDTH-1:0] tcp_hdr,
  output logic                       hdr_valid,
  output logic                       err_runt,
  output logic                       err_oversize
`ifdef PKT_PARSER_STATS_EN
  ,
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                runt_cnt,
  output logic [15:0]                oversize_cnt
`endif
);

  localparam int EW    = ETH_WORDS * WIDTH;
  localparam int IW    = IP_WORDS * WIDTH;
  localparam int TW    = TCP_WORDS * WIDTH;
  localparam int HMAX  = (ETH_WORDS > IP_WORDS) ? ETH_WORDS : IP_WORDS;
  localparam int HMAX2 = (HMAX > TCP_WORDS) ? HMAX : TCP_WORDS;
  localparam int LMAX  = (HMAX2 > MAX_PAYLOAD_WORDS) ? HMAX2 : MAX_PAYLOAD_WORDS;
  localparam int CW    = $clog2(LMAX) + 1;

  localparam logic [CW-1:0] ETH_LAST = CW'(ETH_WORDS - 1);
  localparam logic [CW-1:0] IP_LAST  = CW'(IP_WORDS - 1);
  localparam logic [CW-1:0] TCP_LAST = CW'(TCP_WORDS - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(MAX_PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ETH, S_IP, S_TCP, S_PAY, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    eth_cnt_q, eth_cnt_d, ip_cnt_q, ip_cnt_d;
  logic [CW-1:0]    tcp_cnt_q, tcp_cnt_d, pay_cnt_q, pay_cnt_d;
  logic [EW-1:0]    eth_sh_q, eth_sh_d, eth_hdr_q, eth_hdr_d;
  logic [IW-1:0]    ip_sh_q, ip_sh_d, ip_hdr_q, ip_hdr_d;
  logic [TW-1:0]    tcp_sh_q, tcp_sh_d, tcp_hdr_q, tcp_hdr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic             hdr_valid_q, err_runt_q, err_ov_q;
  logic             beat, publish, runt, oversize;

  // Header regions never stall; only the payload stage applies backpressure.
  assign ready_in = (state_q == S_PAY) ? (!valid_out_q || ready_out) : 1'b1;
  assign beat     = valid_in && ready_in;

  always_comb begin
    state_d     = state_q;
    eth_cnt_d   = eth_cnt_q;
    ip_cnt_d    = ip_cnt_q;
    tcp_cnt_d   = tcp_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    eth_sh_d    = eth_sh_q;
    ip_sh_d     = ip_sh_q;
    tcp_sh_d    = tcp_sh_q;
    eth_hdr_d   = eth_hdr_q;
    ip_hdr_d    = ip_hdr_q;
    tcp_hdr_d   = tcp_hdr_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    publish     = 1'b0;
    runt        = 1'b0;
    oversize    = 1'b0;

    if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
    end

    case (state_q)
      S_IDLE, S_ETH: if (beat) begin
        eth_sh_d = EW'({data_in, eth_sh_q} >> WIDTH);
        if (last_in) begin
          runt = 1'b1;
        end else if (eth_cnt_q == ETH_LAST) begin
          eth_cnt_d = '0;
          state_d   = S_IP;
        end else begin
          eth_cnt_d = eth_cnt_q + CW'(1);
          state_d   = S_ETH;
        end
      end
      S_IP: if (beat) begin
        ip_sh_d = IW'({data_in, ip_sh_q} >> WIDTH);
        if (last_in) begin
          runt = 1'b1;
        end else if (ip_cnt_q == IP_LAST) begin
          ip_cnt_d = '0;
          state_d  = S_TCP;
        end else begin
          ip_cnt_d = ip_cnt_q + CW'(1);
        end
      end
      S_TCP: if (beat) begin
        tcp_sh_d = TW'({data_in, tcp_sh_q} >> WIDTH);
        if (tcp_cnt_q == TCP_LAST) begin
          publish   = 1'b1;
          tcp_cnt_d = '0;
          eth_hdr_d = eth_sh_q;
          ip_hdr_d  = ip_sh_q;
          tcp_hdr_d = tcp_sh_d;
          state_d   = last_in ? S_IDLE : S_PAY;
        end else if (last_in) begin
          runt = 1'b1;
        end else begin
          tcp_cnt_d = tcp_cnt_q + CW'(1);
        end
      end
      S_PAY: if (beat) begin
        data_out_d  = data_in;
        valid_out_d = 1'b1;
        last_out_d  = last_in;
        if (last_in) begin
          pay_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (pay_cnt_q == PAY_LAST) begin
          // Truncate: the limit word closes the packet downstream.
          last_out_d = 1'b1;
          oversize   = 1'b1;
          pay_cnt_d  = '0;
          state_d    = S_DROP;
        end else begin
          pay_cnt_d = pay_cnt_q + CW'(1);
        end
      end
      S_DROP: if (beat && last_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (runt) begin
      state_d   = S_IDLE;
      eth_cnt_d = '0;
      ip_cnt_d  = '0;
      tcp_cnt_d = '0;
      eth_sh_d  = '0;
      ip_sh_d   = '0;
      tcp_sh_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      eth_cnt_q   <= '0;
      ip_cnt_q    <= '0;
      tcp_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      eth_sh_q    <= '0;
      ip_sh_q     <= '0;
      tcp_sh_q    <= '0;
      eth_hdr_q   <= '0;
      ip_hdr_q    <= '0;
      tcp_hdr_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      hdr_valid_q <= 1'b0;
      err_runt_q  <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      eth_cnt_q   <= eth_cnt_d;
      ip_cnt_q    <= ip_cnt_d;
      tcp_cnt_q   <= tcp_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      eth_sh_q    <= eth_sh_d;
      ip_sh_q     <= ip_sh_d;
      tcp_sh_q    <= tcp_sh_d;
      eth_hdr_q   <= eth_hdr_d;
      ip_hdr_q    <= ip_hdr_d;
      tcp_hdr_q   <= tcp_hdr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      hdr_valid_q <= publish;
      err_runt_q  <= runt;
      err_ov_q    <= oversize;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign last_out     = last_out_q;
  assign eth_hdr      = eth_hdr_q;
  assign ip_hdr       = ip_hdr_q;
  assign tcp_hdr      = tcp_hdr_q;
  assign hdr_valid    = hdr_valid_q;
  assign err_runt     = err_runt_q;
  assign err_oversize = err_ov_q;

`ifdef PKT_PARSER_STATS_EN
  logic [15:0] pkt_cnt_q, runt_cnt_q, ov_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q  <= '0;
      runt_cnt_q <= '0;
      ov_cnt_q   <= '0;
    end else begin
      if (hdr_valid_q && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (err_runt_q && runt_cnt_q != 16'hFFFF) runt_cnt_q <= runt_cnt_q + 16'd1;
      if (err_ov_q && ov_cnt_q != 16'hFFFF) ov_cnt_q <= ov_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt      = pkt_cnt_q;
  assign runt_cnt     = runt_cnt_q;
  assign oversize_cnt = ov_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_parser_stream.sv
// Bench for pkt_parser_stream: packet-level reference model plus directed packets
// (normal, backpressure, runt, oversize, zero-payload, reset mid-payload).
module tb_pkt_parser_stream;
  localparam int W    = 32;
  localparam int E    = 4;
  localparam int I    = 5;
  localparam int T    = 5;
  localparam int MAXP = 12;
  localparam int H    = E + I + T;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   data_in = '0;
  logic           valid_in = 1'b0;
  logic           last_in = 1'b0;
  logic           ready_in;
  logic [W-1:0]   data_out;
  logic           valid_out;
  logic           last_out;
  logic           ready_out = 1'b1;
  logic [E*W-1:0] eth_hdr;
  logic [I*W-1:0] ip_hdr;
  logic [T*W-1:0] tcp_hdr;
  logic           hdr_valid, err_runt, err_oversize;
`ifdef PKT_PARSER_STATS_EN
  logic [15:0]    pkt_cnt, runt_cnt, oversize_cnt;
`endif

  pkt_parser_stream #(
    .WIDTH(W), .ETH_WORDS(E), .IP_WORDS(I), .TCP_WORDS(T), .MAX_PAYLOAD_WORDS(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .last_out(last_out),
    .ready_out(ready_out), .eth_hdr(eth_hdr), .ip_hdr(ip_hdr), .tcp_hdr(tcp_hdr),
    .hdr_valid(hdr_valid), .err_runt(err_runt), .err_oversize(err_oversize)
`ifdef PKT_PARSER_STATS_EN
    , .pkt_cnt(pkt_cnt), .runt_cnt(runt_cnt), .oversize_cnt(oversize_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: position within the packet, not parser states.
  int           k = 0;
  bit           dropping = 0;
  logic [W-1:0] hw [H];
  logic [W:0]   exp_q [$];
  logic [W:0]   e_word;
  bit           exp_hv = 0, exp_rn = 0, exp_ov = 0, exp_new = 0, exp_nl = 0;
  logic [W-1:0] exp_nd = '0;
  logic [E*W-1:0] pub_eth = '0;
  logic [I*W-1:0] pub_ip = '0;
  logic [T*W-1:0] pub_tcp = '0;
  bit           prev_stall = 0, prev_l = 0;
  logic [W-1:0] prev_d = '0;
  int           n_hv = 0, n_rn = 0, n_ov = 0, n_out = 0;

  task automatic model_beat(input logic [W-1:0] d, input bit l);
    if (dropping) begin
      if (l) begin
        dropping = 0;
        k = 0;
      end
    end else if (k < H) begin
      hw[k] = d;
      if (k == H - 1) begin
        for (int i = 0; i < E; i++) pub_eth[i*W +: W] = hw[i];
        for (int i = 0; i < I; i++) pub_ip[i*W +: W] = hw[E+i];
        for (int i = 0; i < T; i++) pub_tcp[i*W +: W] = hw[E+I+i];
        exp_hv = 1;
        k = l ? 0 : H;
      end else if (l) begin
        exp_rn = 1;
        k = 0;
      end else begin
        k++;
      end
    end else begin
      bit lo;
      lo = l || (k - H == MAXP - 1);
      exp_q.push_back({lo, d});
      exp_new = 1;
      exp_nd = d;
      exp_nl = lo;
      if (l) k = 0;
      else if (k - H == MAXP - 1) begin
        exp_ov = 1;
        dropping = 1;
        k = 0;
      end else k++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      k = 0; dropping = 0; exp_q.delete();
      exp_hv = 0; exp_rn = 0; exp_ov = 0; exp_new = 0;
      pub_eth = '0; pub_ip = '0; pub_tcp = '0;
      prev_stall = 0;
    end else begin
      chk("hdr_valid", hdr_valid, exp_hv);
      chk("err_runt", err_runt, exp_rn);
      chk("err_oversize", err_oversize, exp_ov);
      if (hdr_valid) n_hv++;
      if (err_runt) n_rn++;
      if (err_oversize) n_ov++;
      chk("eth_hdr", eth_hdr, pub_eth);
      chk("ip_hdr", ip_hdr, pub_ip);
      chk("tcp_hdr", tcp_hdr, pub_tcp);
      if (exp_new) begin
        chk("latency_valid", valid_out, 1'b1);
        chk("latency_data", data_out, exp_nd);
        chk("latency_last", last_out, exp_nl);
      end else if (prev_stall) begin
        chk("stall_valid", valid_out, 1'b1);
        chk("stall_data", data_out, prev_d);
        chk("stall_last", last_out, prev_l);
      end else begin
        chk("valid_idle", valid_out, 1'b0);
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", data_out);
        end else begin
          e_word = exp_q.pop_front();
          chk("out_data", data_out, e_word[W-1:0]);
          chk("out_last", last_out, e_word[W]);
          n_out++;
        end
      end
      if (k >= H && !dropping) chk("ready_in_pay", ready_in, !(valid_out && !ready_out));
      else chk("ready_in_hdr", ready_in, 1'b1);
      prev_stall = valid_out && !ready_out;
      prev_d = data_out;
      prev_l = last_out;
      exp_hv = 0; exp_rn = 0; exp_ov = 0; exp_new = 0;
      if (valid_in && ready_in) model_beat(data_in, last_in);
    end
  end

  bit bp_mode = 0;
  int bp_i = 0;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      ready_out = (bp_i % 4 == 0) || (bp_i % 4 == 3);
      bp_i++;
    end else begin
      ready_out = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit l);
    bit acc;
    acc = 0;
    valid_in = 1'b1;
    data_in = d;
    last_in = l;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    end
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [W-1:0] hbase, input int runt_at, input int npay,
                          input logic [W-1:0] pbase, input bit gaps);
    if (runt_at >= 0) begin
      for (int i = 0; i <= runt_at; i++) send(hbase + W'(i), i == runt_at);
    end else begin
      for (int i = 0; i < H; i++) begin
        send(hbase + W'(i), (i == H - 1) && (npay == 0));
        if (gaps && i % 5 == 2) idle(1);
      end
      for (int i = 0; i < npay; i++) begin
        send(pbase + W'(i), i == npay - 1);
        if (gaps && i % 3 == 1) idle(1);
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (exp_q.size() != 0 || valid_out); t++) idle(1);
    chk("drained", exp_q.size(), 0);
    idle(3);
  endtask

  int h0, o0, r0, v0;
  task automatic mark();
    h0 = n_hv; o0 = n_out; r0 = n_rn; v0 = n_ov;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_eth_hdr", eth_hdr, '0);
    chk("rst_tcp_hdr", tcp_hdr, '0);
    chk("rst_err", {err_runt, err_oversize, last_out}, 3'b000);
    idle(2);
    rst = 1'b1;
    idle(1);

    mark();
    send_pkt(32'h1000, -1, 10, 32'hA0, 0);
    drain();
    chk("t1_eth_w0", eth_hdr[31:0], 32'h1000);
    chk("t1_ip_w0", ip_hdr[31:0], 32'h1004);
    chk("t1_tcp_w4", tcp_hdr[159:128], 32'h100D);
    chk("t1_hv_count", n_hv - h0, 1);
    chk("t1_out_count", n_out - o0, 10);

    mark();
    bp_mode = 1;
    send_pkt(32'h2000, -1, 10, 32'hB0, 1);
    drain();
    bp_mode = 0;
    chk("t2_out_count", n_out - o0, 10);
    chk("t2_hv_count", n_hv - h0, 1);

    mark();
    send_pkt(32'h3000, 6, 0, 32'h0, 0);
    idle(3);
    chk("t3_runt_count", n_rn - r0, 1);
    chk("t3_no_hv", n_hv - h0, 0);
    chk("t3_eth_kept", eth_hdr[31:0], 32'h2000);
    send_pkt(32'h3100, -1, 2, 32'hC0, 0);
    drain();
    chk("t3_clean_eth_w0", eth_hdr[31:0], 32'h3100);
    chk("t3_clean_ip_w0", ip_hdr[31:0], 32'h3104);
    chk("t3_clean_out", n_out - o0, 2);

    mark();
    send_pkt(32'h4000, -1, MAXP + 2, 32'hD0, 0);
    drain();
    chk("t4_out_count", n_out - o0, MAXP);
    chk("t4_ov_count", n_ov - v0, 1);
    chk("t4_tcp_w4", tcp_hdr[159:128], 32'h400D);
    mark();
    send_pkt(32'h4100, -1, MAXP, 32'hE0, 0);
    drain();
    chk("t4_exact_out", n_out - o0, MAXP);
    chk("t4_exact_no_ov", n_ov - v0, 0);

    mark();
    send_pkt(32'h5000, -1, 0, 32'h0, 0);
    send_pkt(32'h5100, -1, 0, 32'h0, 0);
    idle(3);
    chk("t5_hv_count", n_hv - h0, 2);
    chk("t5_no_out", n_out - o0, 0);
    chk("t5_eth_w0", eth_hdr[31:0], 32'h5100);

    for (int i = 0; i < H; i++) send(32'h6000 + W'(i), 1'b0);
    for (int i = 0; i < 3; i++) send(32'hF0 + W'(i), 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_valid_out", valid_out, 1'b0);
    chk("t6_data_out", data_out, '0);
    chk("t6_eth_hdr", eth_hdr, '0);
    chk("t6_tcp_hdr", tcp_hdr, '0);
    chk("t6_last_out", last_out, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
`ifdef PKT_PARSER_STATS_EN
    chk("t6_pkt_cnt_rst", pkt_cnt, 16'd0);
`endif
    mark();
    send_pkt(32'h7000, -1, 3, 32'h70, 0);
    send_pkt(32'h7100, -1, 1, 32'h71, 0);
    drain();
    chk("t6_hv_count", n_hv - h0, 2);
    chk("t6_out_count", n_out - o0, 4);
`ifdef PKT_PARSER_STATS_EN
    chk("t6_pkt_cnt", pkt_cnt, 16'd2);
    chk("t6_runt_cnt", runt_cnt, 16'd0);
    chk("t6_ov_cnt", oversize_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_parser_stream.md
Name: pkt_parser_stream

Overview:
Parametrised second-generation Ethernet/IP/TCP header parser for the packet-source-to-FIFO path. Header lengths are set by parameters, and payload length is delimited by a last_in sideband rather than being fixed. The block has a registered valid/ready output stage, publishes double-buffered headers with a completion strobe, and detects runt and oversize packets.

Parameters:
WIDTH, 32, data bus width in bits (multiple of 8)
ETH_WORDS, 4, Ethernet header length in bus words (>=1)
IP_WORDS, 5, IP header length in bus words (>=1)
TCP_WORDS, 5, TCP header length in bus words (>=1)
MAX_PAYLOAD_WORDS, 256, maximum payload words forwarded per packet (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
data_in  in  WIDTH  input word
valid_in  in  1  upstream word available
last_in  in  1  qualifies final word of packet
ready_in  out  1  parser accepts word; beat = valid_in && ready_in
data_out  out  WIDTH  payload word to FIFO
valid_out  out  1  data_out valid
last_out  out  1  final payload word of packet
ready_out  in  1  FIFO accepts word
eth_hdr  out  ETH_WORDS*WIDTH  last completed Ethernet header
ip_hdr  out  IP_WORDS*WIDTH  last completed IP header
tcp_hdr  out  TCP_WORDS*WIDTH  last completed TCP header
hdr_valid  out  1  one-cycle pulse: header outputs updated
err_runt  out  1  one-cycle pulse: last_in during headers
err_oversize  out  1  one-cycle pulse: payload truncated

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE; all counters 0; valid_out, last_out, hdr_valid, err_* = 0; data_out and all header outputs/shadows = 0.
- FSM states: IDLE, ETH_HDR, IP_HDR, TCP_HDR, PAYLOAD, DROP. One word counter per region, sized $clog2 of the largest region plus 1.
- IDLE: ready_in=1. The first beat is Ethernet word 0. If ETH_WORDS==1 it also completes that region; otherwise go to ETH_HDR.
- Header capture: each beat shifts into a shadow register as {data_in, shadow[top:WIDTH]}, so word 0 ends at bits [WIDTH-1:0].
- Region completion: on the beat with region count == N-1, advance ETH->IP->TCP.
- ready_in is 1 in all header states.
- TCP header completion: on the final TCP beat, copy all shadows to eth_hdr/ip_hdr/tcp_hdr. hdr_valid pulses the next cycle. Outputs then hold until the next packet completes.
- Zero-length payload: if last_in is set on the final TCP beat, headers publish as normal and the FSM returns to IDLE. No payload word is emitted.
- Runt: last_in on any header beat before TCP completion. err_runt pulses the next cycle, shadows are discarded, hdr_valid is not asserted, state returns to IDLE.
- PAYLOAD: ready_in = !valid_out || ready_out (single output register, no bubble).
- Payload beat: data_out<=data_in, valid_out<=1, last_out<=last_in, giving 1-cycle latency.
- Output hold: valid_out clears only on valid_out && ready_out with no new beat. data_out/last_out hold stable while valid_out && !ready_out.
- last_in accepted in PAYLOAD returns the FSM to IDLE. The next packet may begin the following cycle even while the last word still waits at the output.
- Oversize: on the beat that makes the payload count == MAX_PAYLOAD_WORDS without last_in, forward it with last_out forced to 1. err_oversize pulses and the FSM goes to DROP.
- DROP: ready_in=1; words are discarded until last_in is accepted, then IDLE. A last_in coinciding with the MAX-th word ends the packet normally with no error.
- valid_in low: no state or counter change in any state; gaps are allowed anywhere.
- Reset mid-packet: immediate return to reset values; any partially emitted packet is lost.

Optional Feature:
PKT_PARSER_STATS_EN. When defined, add outputs pkt_cnt[15:0], runt_cnt[15:0] and oversize_cnt[15:0]:
- pkt_cnt increments on each hdr_valid.
- The other two increment on their respective error pulses.
- All saturate at 16'hFFFF and reset to 0.
When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Normal packet, defaults: 14 header beats with words 0x1000+i, then 10 payload beats 0xA0..0xA9 with last on 0xA9, ready_out=1 -> eth_hdr[31:0]=0x1000, tcp_hdr[159:128]=0x100D. hdr_valid pulses once; 10 outputs each 1 cycle after input; last_out only with 0xA9.
- Backpressure: same packet with ready_out toggling 1,0,0,1 -> no payload word lost or duplicated; data_out stable while stalled; ready_in=0 while the output is full and stalled.
- Runt: last_in on beat 7 (IP region) -> err_runt pulses once; hdr_valid never asserts; the next clean packet parses correctly.
- Oversize: MAX_PAYLOAD_WORDS=4, 6 payload words -> 4 words out, last_out on the 4th, err_oversize pulses; words 5-6 consumed (ready_in=1) and dropped.
- Zero payload and back-to-back: last_in on the 14th beat, then an immediate next packet with valid_in held high -> hdr_valid pulses twice; no valid_out for the first packet.
- Reset mid-payload, then STATS_EN counters: assert rst low after 3 payload words -> all outputs 0 immediately; with PKT_PARSER_STATS_EN, pkt_cnt=0 after reset and 2 after the next two good packets.
